reg_file_sb: RTL and testbench

- Parametrised integer register file with an integrated write scoreboard, for the pipelined/multi-cycle successor of the rv32i core.
- Provides two combinational read ports and one synchronous writeback port, plus per-register busy (pending-write) bits.
- Tracks an outstanding-write count so the issue stage can detect RAW and WAW hazards and stall.
- Register 0 is hardwired to zero and never tracked.

---
 rtl/reg_file_sb.sv | 128 ++++++++++++
 tb/tb_reg_file_sb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard: two combinational read
// ports, one writeback port, per-register busy bits and a busy count.
// Optional same-cycle writeback forwarding: define REGFILE_WR_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [CW-1:0]   pend_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    cnt;

    logic wb_en;
    logic iss_set;
    logic cnt_inc;
    logic cnt_dec;

    // x0 is never written and never marked busy.
    assign wb_en   = wb_valid && (wb_rd != '0);
    assign iss_set = iss_valid && iss_ready && (iss_rd != '0);

    // A same-rd reservation keeps the bit set, so the writeback retires nothing.
    assign cnt_inc = iss_set && !busy[iss_rd];
    assign cnt_dec = wb_en && busy[wb_rd] && !(iss_set && (iss_rd == wb_rd));

    // Reservation: one outstanding write per register (busy dest is a WAW stall).
    always_comb begin
        iss_ready = (iss_rd == '0) || !busy[iss_rd];
`ifdef REGFILE_WR_BYPASS_EN
        if (wb_en && (wb_rd == iss_rd)) begin
            iss_ready = 1'b1;
        end
`endif
    end

    // Read port 1.
    // NOTE: every output of an always_comb gets a default on entry; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
`ifdef REGFILE_WR_BYPASS_EN
        if (wb_en && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
        end
`endif
        if (rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end
    end

    // Read port 2.
    always_comb begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
`ifdef REGFILE_WR_BYPASS_EN
        if (wb_en && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
        end
`endif
        if (rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end
    end

    // Clear for the retiring writer first, then set for the new producer so
    // that a same-rd reservation wins.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (iss_set) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    // NOTE: the register array is reset along with the scoreboard because the
    // architectural state must read as zero after rst; this costs a reset mux
    // per flop and rules out mapping the array onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
            cnt  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (wb_en) begin
                regs[wb_rd] <= wb_data;
            end
            busy <= busy_next;
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pend_cnt = cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios then random traffic,
// checked against an array-based model of the register file and busy set.
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;
`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [CW-1:0]   pend_cnt;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            b1;
        logic            b2;
        logic            rdy;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t            sb_q[$];
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              total = 0;
    int              bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int m_pop();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // One clock of stimulus: drive, predict the visible outputs, advance the model.
    task automatic cycle(input bit r, input bit iv, input logic [AW-1:0] ird,
                         input bit wv, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        bit   fwd1, fwd2, rdy;
        rst = r; iss_valid = iv; iss_rd = ird;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        fwd1 = BYP && wv && (wrd != 0) && (wrd == a1);
        fwd2 = BYP && wv && (wrd != 0) && (wrd == a2);
        e.d1 = (a1 == 0) ? '0 : (fwd1 ? wd : m_regs[a1]);
        e.b1 = (a1 == 0 || fwd1) ? 1'b0 : m_busy[a1];
        e.d2 = (a2 == 0) ? '0 : (fwd2 ? wd : m_regs[a2]);
        e.b2 = (a2 == 0 || fwd2) ? 1'b0 : m_busy[a2];
        rdy  = (ird == 0) || !m_busy[ird] || (BYP && wv && (wrd == ird));
        e.rdy = rdy;
        e.cnt = CW'(m_pop());
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_clear();
        end else begin
            if (wv && wrd != 0) begin
                m_regs[wrd] = wd;
                m_busy[wrd] = 1'b0;
            end
            if (iv && rdy && ird != 0) m_busy[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic rd2(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cycle(0, 0, 0, 0, 0, '0, a1, a2);
    endtask

    // Monitor: outputs are combinational, so one expectation is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rs1_data",  64'(rs1_data),  64'(e.d1));
            check("rs2_data",  64'(rs2_data),  64'(e.d2));
            check("rs1_busy",  64'(rs1_busy),  64'(e.b1));
            check("rs2_busy",  64'(rs2_busy),  64'(e.b2));
            check("iss_ready", 64'(iss_ready), 64'(e.rdy));
            check("pend_cnt",  64'(pend_cnt),  64'(e.cnt));
        end
    end

    initial begin
        logic [AW-1:0] lo_mask;
        m_clear();
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0;
        wb_rd = '0; wb_data = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset: every address reads zero / idle, all reservations ready.
        for (int a = 0; a < NREGS; a++) begin
            cycle(0, 0, AW'(a), 0, 0, '0, AW'(a), AW'(NREGS - 1 - a));
        end

        // Writeback x5, discarded writeback to x0.
        cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        cycle(0, 0, 0, 1, 0, 32'h00001234, 5, 0);
        rd2(5, 0);

        // Reserve x7, WAW stall on x7, retire x7.
        cycle(0, 1, 7, 0, 0, '0, 0, 7);
        cycle(0, 1, 7, 0, 0, '0, 0, 7);
        cycle(0, 0, 7, 1, 7, 32'h55, 7, 7);
        rd2(7, 7);

        // Same-cycle reserve and writeback of idle x9.
        cycle(0, 1, 9, 1, 9, 32'hA5, 9, 9);
        rd2(9, 9);

        // Retire x9 while re-reserving it: legal only with forwarding.
        cycle(0, 1, 9, 1, 9, 32'h5A, 9, 0);
        rd2(9, 9);

        // Reservations then reset with a writeback in flight.
        cycle(0, 1, 3, 0, 0, '0, 3, 4);
        cycle(0, 1, 4, 0, 0, '0, 3, 4);
        cycle(0, 1, 6, 0, 0, '0, 6, 5);
        cycle(1, 1, 8, 1, 3, 32'hCAFE, 3, 6);
        rd2(3, 6);
        rd2(4, 5);

        // Same-cycle read of a register being written.
        cycle(0, 0, 0, 1, 10, 32'h11, 0, 0);
        cycle(0, 0, 0, 1, 10, 32'h77, 10, 0);
        rd2(10, 10);

        // Random traffic; half the time confined to x0..x7 to force collisions.
        for (int n = 0; n < 1500; n++) begin
            lo_mask = ($urandom_range(0, 1) == 0) ? AW'(7) : '1;
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1, AW'($urandom) & lo_mask,
                  $urandom_range(0, 2) != 0, AW'($urandom) & lo_mask, XLEN'($urandom),
                  AW'($urandom) & lo_mask, AW'($urandom) & lo_mask);
        end
        cycle(0, 0, 0, 0, 0, '0, 1, 2);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
